branch_redirect_unit: RTL and testbench

- Fetch-steering and branch-resolution block for the 5-stage core.
- Owns the fetch PC register and consumes the per-fetch prediction (taken flag + target) from the predictor.
- Carries prediction metadata down the F→D→E pipeline and checks it against the branch outcome resolved in EX.
- Issues redirect/flush on mispredicts and keeps saturating branch/mispredict performance counters.

---
 rtl/branch_redirect_unit_if.sv | 41 ++++
 rtl/branch_redirect_unit.sv | 137 +++++++++++++
 tb/tb_branch_redirect_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_redirect_unit_if.sv
// Signal bundle between the branch redirect unit and the rest of the core.
// There is no valid/ready handshake here: inputs are sampled every posedge, outputs are level signals.
interface branch_redirect_unit_if #(
  parameter int CNT_W = 32
);
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             flush_d_ext;
  logic             flush_e_ext;
  logic             pred_taken_f;
  logic [31:0]      pred_target_f;
  logic [2:0]       br_type_e;
  logic             br_taken_e;
  logic [31:0]      br_target_e;

  logic [31:0]      pc_f;
  logic [31:0]      pc_e;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             flush_d;
  logic             flush_e;
  logic             mispred_taken;
  logic             mispred_nottaken;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output stall_f, stall_d, stall_e, flush_d_ext, flush_e_ext,
           pred_taken_f, pred_target_f, br_type_e, br_taken_e, br_target_e,
    input  pc_f, pc_e, redirect, redirect_pc, flush_d, flush_e,
           mispred_taken, mispred_nottaken, branch_cnt, mispred_cnt
  );

  modport slave (
    input  stall_f, stall_d, stall_e, flush_d_ext, flush_e_ext,
           pred_taken_f, pred_target_f, br_type_e, br_taken_e, br_target_e,
    output pc_f, pc_e, redirect, redirect_pc, flush_d, flush_e,
           mispred_taken, mispred_nottaken, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_redirect_unit.sv
// Fetch PC steering plus F->D->E prediction tracking; checks predictions in EX,
// redirects fetch on mispredict and keeps saturating branch/mispredict counters.
module branch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input logic                   clk,
  input logic                   rst,
  branch_redirect_unit_if.slave bus
);

  logic [31:0]      r_pc_f;

  logic             r_d_valid;
  logic [31:0]      r_d_pc;
  logic             r_d_pred;
  logic [31:0]      r_d_tgt;

  logic             r_e_valid;
  logic [31:0]      r_e_pc;
  logic             r_e_pred;
  logic [31:0]      r_e_tgt;

  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic             w_resolve;
  logic             w_is_br;
  logic             w_actual_taken;
  logic             w_mp_taken;
  logic             w_mp_nottaken;
  logic             w_tgt_wrong;
  logic             w_redirect;
  logic [31:0]      w_redirect_pc;
  logic             w_flush_d;
  logic             w_flush_e;
  logic [31:0]      w_pc_f_next;

  // EX resolution is only acted on when E holds a real instruction that is not stalled.
  assign w_resolve      = r_e_valid & ~bus.stall_e;
  assign w_is_br        = |bus.br_type_e;
  assign w_actual_taken = w_is_br & bus.br_taken_e;

  assign w_mp_nottaken  = w_resolve & w_actual_taken & ~r_e_pred;
  assign w_mp_taken     = w_resolve & r_e_pred & ~w_actual_taken;
  assign w_tgt_wrong    = w_resolve & w_actual_taken & r_e_pred
                          & (r_e_tgt != bus.br_target_e);
  assign w_redirect     = w_mp_nottaken | w_mp_taken | w_tgt_wrong;
  assign w_redirect_pc  = w_actual_taken ? bus.br_target_e : (r_e_pc + 32'd4);

  assign w_flush_d      = bus.flush_d_ext | w_redirect;
  assign w_flush_e      = bus.flush_e_ext | w_redirect;

  always_comb begin
    w_pc_f_next = r_pc_f + 32'd4;
    if (w_redirect) begin
      w_pc_f_next = w_redirect_pc;
    end else if (bus.stall_f) begin
      w_pc_f_next = r_pc_f;
    end else if (bus.pred_taken_f) begin
      w_pc_f_next = bus.pred_target_f;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc_f <= RESET_PC;
    end else begin
      r_pc_f <= w_pc_f_next;
    end
  end

  // A flushed register keeps its pc/target; only valid and the prediction are cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_valid <= 1'b0;
      r_d_pc    <= 32'h0;
      r_d_pred  <= 1'b0;
      r_d_tgt   <= 32'h0;
    end else if (!bus.stall_d) begin
      if (w_flush_d) begin
        r_d_valid <= 1'b0;
        r_d_pred  <= 1'b0;
      end else begin
        r_d_valid <= 1'b1;
        r_d_pc    <= r_pc_f;
        r_d_pred  <= bus.pred_taken_f;
        r_d_tgt   <= bus.pred_target_f;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e_valid <= 1'b0;
      r_e_pc    <= 32'h0;
      r_e_pred  <= 1'b0;
      r_e_tgt   <= 32'h0;
    end else if (!bus.stall_e) begin
      if (w_flush_e) begin
        r_e_valid <= 1'b0;
        r_e_pred  <= 1'b0;
      end else begin
        r_e_valid <= r_d_valid;
        r_e_pc    <= r_d_pc;
        r_e_pred  <= r_d_pred;
        r_e_tgt   <= r_d_tgt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (w_resolve) begin
      if (w_is_br && (r_branch_cnt != '1)) begin
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (w_redirect && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pc_f             = r_pc_f;
  assign bus.pc_e             = r_e_pc;
  assign bus.redirect         = w_redirect;
  assign bus.redirect_pc      = w_redirect_pc;
  assign bus.flush_d          = w_flush_d;
  assign bus.flush_e          = w_flush_e;
  assign bus.mispred_taken    = w_mp_taken;
  assign bus.mispred_nottaken = w_mp_nottaken;
  assign bus.branch_cnt       = r_branch_cnt;
  assign bus.mispred_cnt      = r_mispred_cnt;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: a 32-bit-counter instance plus a 4-bit-counter
// instance fed the same stimulus so counter saturation can be observed.
module tb_branch_redirect_unit;

  logic clk;
  logic rst;

  int chk_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_q[$];

  branch_redirect_unit_if #(.CNT_W(32)) bus_b ();
  branch_redirect_unit_if #(.CNT_W(4))  bus_s ();

  branch_redirect_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  branch_redirect_unit #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  assign bus_s.stall_f       = bus_b.stall_f;
  assign bus_s.stall_d       = bus_b.stall_d;
  assign bus_s.stall_e       = bus_b.stall_e;
  assign bus_s.flush_d_ext   = bus_b.flush_d_ext;
  assign bus_s.flush_e_ext   = bus_b.flush_e_ext;
  assign bus_s.pred_taken_f  = bus_b.pred_taken_f;
  assign bus_s.pred_target_f = bus_b.pred_target_f;
  assign bus_s.br_type_e     = bus_b.br_type_e;
  assign bus_s.br_taken_e    = bus_b.br_taken_e;
  assign bus_s.br_target_e   = bus_b.br_target_e;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_br(input logic [2:0] t, input logic tk, input logic [31:0] tg);
    bus_b.br_type_e   = t;
    bus_b.br_taken_e  = tk;
    bus_b.br_target_e = tg;
  endtask

  task automatic set_pred(input logic tk, input logic [31:0] tg);
    bus_b.pred_taken_f  = tk;
    bus_b.pred_target_f = tg;
  endtask

  task automatic set_stalls(input logic f, input logic d, input logic e);
    bus_b.stall_f = f;
    bus_b.stall_d = d;
    bus_b.stall_e = e;
  endtask

  initial begin
    rst = 1'b1;
    set_stalls(1'b0, 1'b0, 1'b0);
    bus_b.flush_d_ext = 1'b1;
    bus_b.flush_e_ext = 1'b0;
    set_pred(1'b0, 32'h0);
    set_br(3'd0, 1'b0, 32'h0);
    #2;

    // reset state
    check("rst_pc_f", bus_b.pc_f, 32'h0);
    check("rst_pc_e", bus_b.pc_e, 32'h0);
    check("rst_redirect", {31'h0, bus_b.redirect}, 32'h0);
    check("rst_flush_d_ext", {31'h0, bus_b.flush_d}, 32'h1);
    check("rst_flush_e", {31'h0, bus_b.flush_e}, 32'h0);
    check("rst_branch_cnt", bus_b.branch_cnt, 32'h0);
    check("rst_mispred_cnt", bus_b.mispred_cnt, 32'h0);
    bus_b.flush_d_ext = 1'b0;
    step();
    rst = 1'b0;
    settle();

    // sequential fetch
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check("seq_pc_f", bus_b.pc_f, e);
      if (i < 2) step();
    end
    check("seq_branch_cnt", bus_b.branch_cnt, 32'h0);

    // correctly predicted taken branch at 0x8 -> 0x100
    set_pred(1'b1, 32'h100);
    step();
    check("pred_pc_f", bus_b.pc_f, 32'h100);
    set_pred(1'b0, 32'h0);
    step();
    set_br(3'd1, 1'b1, 32'h100);
    settle();
    check("ok_pc_e", bus_b.pc_e, 32'h8);
    check("ok_redirect", {31'h0, bus_b.redirect}, 32'h0);
    step();
    set_br(3'd0, 1'b0, 32'h0);
    check("ok_branch_cnt", bus_b.branch_cnt, 32'h1);
    check("ok_mispred_cnt", bus_b.mispred_cnt, 32'h0);

    // steer to 0x20 via a correctly predicted branch at 0x108
    set_pred(1'b1, 32'h20);
    step();
    set_pred(1'b0, 32'h0);
    step();
    set_br(3'd1, 1'b1, 32'h20);
    settle();
    check("steer_redirect", {31'h0, bus_b.redirect}, 32'h0);
    step();

    // predicted not taken at 0x20, resolves taken to 0x80
    set_br(3'd1, 1'b1, 32'h80);
    settle();
    check("mnt_pc_e", bus_b.pc_e, 32'h20);
    check("mnt_redirect", {31'h0, bus_b.redirect}, 32'h1);
    check("mnt_redirect_pc", bus_b.redirect_pc, 32'h80);
    check("mnt_mispred_nottaken", {31'h0, bus_b.mispred_nottaken}, 32'h1);
    check("mnt_mispred_taken", {31'h0, bus_b.mispred_taken}, 32'h0);
    check("mnt_flush_d", {31'h0, bus_b.flush_d}, 32'h1);
    check("mnt_flush_e", {31'h0, bus_b.flush_e}, 32'h1);
    step();
    check("mnt_next_pc_f", bus_b.pc_f, 32'h80);
    check("mnt_mispred_cnt", bus_b.mispred_cnt, 32'h1);
    check("mnt_branch_cnt", bus_b.branch_cnt, 32'h3);
    set_br(3'd1, 1'b1, 32'h999);
    settle();
    check("bubble_no_redirect", {31'h0, bus_b.redirect}, 32'h0);
    set_br(3'd0, 1'b0, 32'h0);

    // 0x80 predicted taken to 0x40, 0x40 predicted taken to 0x300
    set_pred(1'b1, 32'h40);
    step();
    set_pred(1'b1, 32'h300);
    step();
    set_pred(1'b0, 32'h0);
    set_br(3'd1, 1'b1, 32'h40);
    step();
    set_br(3'd0, 1'b0, 32'h0);
    settle();
    check("alias_pc_e", bus_b.pc_e, 32'h40);
    check("alias_mispred_taken", {31'h0, bus_b.mispred_taken}, 32'h1);
    check("alias_mispred_nottaken", {31'h0, bus_b.mispred_nottaken}, 32'h0);
    check("alias_redirect_pc", bus_b.redirect_pc, 32'h44);
    step();
    check("alias_next_pc_f", bus_b.pc_f, 32'h44);
    check("alias_branch_cnt", bus_b.branch_cnt, 32'h4);
    check("alias_mispred_cnt", bus_b.mispred_cnt, 32'h2);

    // mispredict held by stall_e for 3 cycles
    step();
    step();
    set_br(3'd2, 1'b1, 32'h500);
    set_stalls(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall_redirect", {31'h0, bus_b.redirect}, 32'h0);
      check("stall_pc_f", bus_b.pc_f, 32'h4c);
      step();
    end
    set_stalls(1'b0, 1'b0, 1'b0);
    settle();
    check("unstall_pc_e", bus_b.pc_e, 32'h44);
    check("unstall_redirect", {31'h0, bus_b.redirect}, 32'h1);
    check("unstall_redirect_pc", bus_b.redirect_pc, 32'h500);
    step();
    set_br(3'd0, 1'b0, 32'h0);
    check("unstall_next_pc_f", bus_b.pc_f, 32'h500);
    check("unstall_mispred_cnt", bus_b.mispred_cnt, 32'h3);
    step();
    check("once_mispred_cnt", bus_b.mispred_cnt, 32'h3);
    check("once_branch_cnt", bus_b.branch_cnt, 32'h5);

    // wrong predicted target: 0x200 predicted, 0x300 actual; redirect beats stall_f
    set_pred(1'b1, 32'h200);
    step();
    set_pred(1'b0, 32'h0);
    step();
    set_br(3'd1, 1'b1, 32'h300);
    bus_b.stall_f = 1'b1;
    settle();
    check("tgt_redirect", {31'h0, bus_b.redirect}, 32'h1);
    check("tgt_redirect_pc", bus_b.redirect_pc, 32'h300);
    check("tgt_mispred_taken", {31'h0, bus_b.mispred_taken}, 32'h0);
    step();
    bus_b.stall_f = 1'b0;
    set_br(3'd0, 1'b0, 32'h0);
    check("tgt_next_pc_f", bus_b.pc_f, 32'h300);
    check("tgt_mispred_cnt", bus_b.mispred_cnt, 32'h4);

    // wraparound: predicted-taken non-branch at 0xFFFF_FFFC falls through to 0
    set_pred(1'b1, 32'hFFFF_FFFC);
    step();
    set_pred(1'b1, 32'h600);
    step();
    set_pred(1'b0, 32'h0);
    set_br(3'd1, 1'b1, 32'hFFFF_FFFC);
    step();
    set_br(3'd0, 1'b0, 32'h0);
    settle();
    check("wrap_pc_e", bus_b.pc_e, 32'hFFFF_FFFC);
    check("wrap_redirect_pc", bus_b.redirect_pc, 32'h0);
    step();
    check("wrap_next_pc_f", bus_b.pc_f, 32'h0);
    check("wrap_branch_cnt", bus_b.branch_cnt, 32'h7);
    check("wrap_mispred_cnt", bus_b.mispred_cnt, 32'h5);
    check("small_mispred_cnt", {28'h0, bus_s.mispred_cnt}, 32'h5);

    // 15 more mispredicts: 4-bit counters saturate at 15
    for (int i = 0; i < 15; i++) begin
      step();
      step();
      set_br(3'd1, 1'b1, 32'h0);
      settle();
      check("loop_redirect", {31'h0, bus_b.redirect}, 32'h1);
      step();
      set_br(3'd0, 1'b0, 32'h0);
      if (i == 9) check("sat_reach", {28'h0, bus_s.mispred_cnt}, 32'hF);
    end
    check("sat_small_mispred", {28'h0, bus_s.mispred_cnt}, 32'hF);
    check("sat_small_branch", {28'h0, bus_s.branch_cnt}, 32'hF);
    check("sat_big_mispred", bus_b.mispred_cnt, 32'd20);
    check("sat_big_branch", bus_b.branch_cnt, 32'd22);

    // reset during a redirect
    step();
    step();
    set_br(3'd1, 1'b1, 32'h700);
    settle();
    check("rstmid_redirect", {31'h0, bus_b.redirect}, 32'h1);
    rst = 1'b1;
    settle();
    check("rstmid_pc_f", bus_b.pc_f, 32'h0);
    check("rstmid_no_redirect", {31'h0, bus_b.redirect}, 32'h0);
    check("rstmid_mispred_cnt", bus_b.mispred_cnt, 32'h0);
    step();
    rst = 1'b0;
    set_br(3'd0, 1'b0, 32'h0);
    step();
    check("rstmid_restart", bus_b.pc_f, 32'h4);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
